// File: rtl/butterfly_writeback_address_gen_unit_pkg.sv
// Shared definitions for the butterfly write-back address generator.
package butterfly_writeback_address_gen_unit_pkg;

    // Controller state; the encoding matches the read generator and the FFT controller.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Legal butterfly latency range in cycles.
    localparam int unsigned BfLatMin = 1;
    localparam int unsigned BfLatMax = 16;

    // Layer counter width: $clog2(awl), never narrower than one bit.
    function automatic int unsigned lay_cnt_width(input int unsigned awl);
        return (awl > 2) ? $clog2(awl) : 1;
    endfunction

endpackage

// File: rtl/butterfly_writeback_address_gen_unit_if.sv
// Read-pair input and write-back output bundle of the write-back address generator.
interface butterfly_writeback_address_gen_unit_if #(
    parameter int unsigned AWL = 5
) ();

    logic           start;
    logic           rd_valid;
    logic [AWL-1:0] rd_a_addr;
    logic [AWL-1:0] rd_b_addr;
    logic           wr_en;
    logic [AWL-1:0] wr_a_addr;
    logic [AWL-1:0] wr_b_addr;
    logic           lay_done;
    logic           fft_done;
    logic           busy;
    logic           err;

    // Controller / read-generator side.
    modport master (
        output start, rd_valid, rd_a_addr, rd_b_addr,
        input  wr_en, wr_a_addr, wr_b_addr, lay_done, fft_done, busy, err
    );

    // Write-back address generator side.
    modport slave (
        input  start, rd_valid, rd_a_addr, rd_b_addr,
        output wr_en, wr_a_addr, wr_b_addr, lay_done, fft_done, busy, err
    );

endinterface

// File: rtl/butterfly_writeback_address_gen_unit_delay_line.sv
// Free-running delay line for {valid, a, b} read pairs, with a synchronous flush.
module butterfly_writeback_address_gen_unit_delay_line #(
    parameter int unsigned BITNESS = 11,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [BITNESS-1:0] d,
    output logic [BITNESS-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        // The consumer's own output register is the only stage.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, clr};
        assign q = d;
    end else begin : g_chain
        logic [BITNESS-1:0] stage_q [DEPTH];

        // Shift one stage per cycle; clr empties every stage in a single cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else if (clr) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/butterfly_writeback_address_gen_unit.sv
// Replays butterfly read-address pairs as write-back addresses after the butterfly latency
// and counts completed butterflies to produce layer-done and FFT-done events.
module butterfly_writeback_address_gen_unit
    import butterfly_writeback_address_gen_unit_pkg::*;
#(
    parameter int unsigned AWL    = 5,
    parameter int unsigned BF_LAT = 3  // legal range BfLatMin..BfLatMax
) (
    input logic                                  clk,
    input logic                                  rst_n,
    butterfly_writeback_address_gen_unit_if.slave bus
);

    localparam int unsigned HalfN     = 2 ** (AWL - 1);
    localparam int unsigned CntW      = (AWL > 1) ? AWL - 1 : 1;
    localparam int unsigned LayW      = lay_cnt_width(AWL);
    localparam int unsigned LineW     = 2 * AWL + 1;
    // The registered write outputs form the final latency stage.
    localparam int unsigned LineDepth = BF_LAT - 1;

    localparam logic [CntW-1:0] CntLast = CntW'(HalfN - 1);
    localparam logic [LayW-1:0] LayLast = LayW'(AWL - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [LayW-1:0] lay_cnt_q, lay_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AWL-1:0]  wr_a_q, wr_a_d;
    logic [AWL-1:0]  wr_b_q, wr_b_d;
    logic            lay_done_q, lay_done_d;
    logic            fft_done_q, fft_done_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic             start_acc;
    logic [LineW-1:0] line_in;
    logic [LineW-1:0] line_out;
    logic             out_valid;
    logic [AWL-1:0]   out_a;
    logic [AWL-1:0]   out_b;

    // Pairs are only entered while running; anything issued in IDLE is discarded here.
    assign start_acc = (state_q == StIdle) && bus.start;
    assign line_in   = {bus.rd_valid && (state_q == StRun), bus.rd_a_addr, bus.rd_b_addr};

    butterfly_writeback_address_gen_unit_delay_line #(
        .BITNESS (LineW),
        .DEPTH   (LineDepth)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .d     (line_in),
        .q     (line_out)
    );

    assign out_valid = line_out[LineW-1];
    assign out_a     = line_out[2*AWL-1:AWL];
    assign out_b     = line_out[AWL-1:0];

    // Next-state: FSM, write/layer counting, write-back gating and error tracking.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        lay_cnt_d  = lay_cnt_q;
        wr_en_d    = 1'b0;
        wr_a_d     = wr_a_q;
        wr_b_d     = wr_b_q;
        lay_done_d = 1'b0;
        fft_done_d = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StRun;
                    wr_cnt_d  = '0;
                    lay_cnt_d = '0;
                    err_d     = 1'b0;
                end else if (bus.rd_valid || out_valid) begin
                    // Stray read issue, or a leftover pair surfacing after the transform ended.
                    err_d = 1'b1;
                end
            end
            StRun: begin
                if (wr_en_q) begin
                    if (wr_cnt_q == CntLast) begin
                        wr_cnt_d   = '0;
                        lay_done_d = 1'b1;
                        if (lay_cnt_q == LayLast) begin
                            fft_done_d = 1'b1;
                            state_d    = StIdle;
                            lay_cnt_d  = '0;
                        end else begin
                            lay_cnt_d = lay_cnt_q + 1'b1;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                if (out_valid) begin
                    if (fft_done_d) begin
                        // All N/2*AWL writes are already out; a surplus pair is an error.
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        wr_a_d  = out_a;
                        wr_b_d  = out_b;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stay busy through the FFT_DONE cycle even though the FSM is back in IDLE.
        busy_d = (state_d == StRun) || fft_done_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_cnt_q   <= '0;
            lay_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_a_q     <= '0;
            wr_b_q     <= '0;
            lay_done_q <= 1'b0;
            fft_done_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            lay_cnt_q  <= lay_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_a_q     <= wr_a_d;
            wr_b_q     <= wr_b_d;
            lay_done_q <= lay_done_d;
            fft_done_q <= fft_done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_a_addr = wr_a_q;
    assign bus.wr_b_addr = wr_b_q;
    assign bus.lay_done  = lay_done_q;
    assign bus.fft_done  = fft_done_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_butterfly_writeback_address_gen_unit.sv
// Scoreboard bench: two DUTs (BF_LAT=2 and BF_LAT=1, AWL=3) driven with identical stimulus.
module tb_butterfly_writeback_address_gen_unit;

    localparam int AWL    = 3;
    localparam int HALF_N = 4;
    localparam int TOTAL  = 12;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [7:0]  idx;
        logic [31:0] t;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    butterfly_writeback_address_gen_unit_if #(.AWL(AWL)) bus0 ();
    butterfly_writeback_address_gen_unit_if #(.AWL(AWL)) bus1 ();

    butterfly_writeback_address_gen_unit #(.AWL(AWL), .BF_LAT(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    butterfly_writeback_address_gen_unit #(.AWL(AWL), .BF_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t       sb [2][$];
    int         lat [2] = '{2, 1};
    int         checks;
    int         failures;
    logic       pend_lay [2];
    logic       pend_fft [2];
    logic       post_fft [2];
    logic       done_seen [2];
    logic [2:0] last_a [2];
    logic [2:0] last_b [2];
    logic       m_run;
    int         m_cnt;

    task automatic chk(input string name, input int g, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, required %0d", name, g, cyc, act, req);
        end
    endtask

    // Reference pair for write i of a standard DIT transform with N=8.
    function automatic logic [2:0] std_a(input int i);
        int span = 1 << (i / HALF_N);
        int j    = i % HALF_N;
        return 3'((j / span) * 2 * span + (j % span));
    endfunction

    function automatic logic [2:0] std_b(input int i);
        return std_a(i) + 3'(1 << (i / HALF_N));
    endfunction

    task automatic mon(input int g, input logic en, input logic [2:0] a, input logic [2:0] b,
                       input logic ld, input logic fd, input logic bs);
        exp_t e;
        if (ld || pend_lay[g]) chk("lay_done", g, int'(ld), int'(pend_lay[g]));
        if (fd || pend_fft[g]) chk("fft_done", g, int'(fd), int'(pend_fft[g]));
        if (post_fft[g]) chk("busy_after_fft", g, int'(bs), 0);
        post_fft[g] = fd;
        if (fd) begin
            chk("busy_in_fft_cycle", g, int'(bs), 1);
            done_seen[g] = 1'b1;
        end
        pend_lay[g] = 1'b0;
        pend_fft[g] = 1'b0;
        if (en) begin
            chk("write_expected", g, int'(sb[g].size() > 0), 1);
            if (sb[g].size() > 0) begin
                e = sb[g].pop_front();
                chk("wr_a_addr", g, int'(a), int'(e.a));
                chk("wr_b_addr", g, int'(b), int'(e.b));
                chk("wr_latency_cycle", g, cyc, int'(e.t));
                pend_lay[g] = (int'(e.idx) % HALF_N) == HALF_N - 1;
                pend_fft[g] = int'(e.idx) == TOTAL - 1;
                last_a[g]   = e.a;
                last_b[g]   = e.b;
            end
        end else begin
            chk("wr_a_hold", g, int'(a), int'(last_a[g]));
            chk("wr_b_hold", g, int'(b), int'(last_b[g]));
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [2:0] a, input logic [2:0] b);
        @(posedge clk);
        #1;
        bus0.start = st; bus0.rd_valid = v; bus0.rd_a_addr = a; bus0.rd_b_addr = b;
        bus1.start = st; bus1.rd_valid = v; bus1.rd_a_addr = a; bus1.rd_b_addr = b;
        if (v && m_run) begin
            for (int g = 0; g < 2; g++) begin
                sb[g].push_back('{a, b, 8'(m_cnt), 32'(cyc + lat[g])});
            end
            m_cnt++;
        end
        if (st && !m_run) begin
            m_run        = 1'b1;
            m_cnt        = 0;
            done_seen[0] = 1'b0;
            done_seen[1] = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done_seen[0] && done_seen[1]) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fft_done_seen", 0, int'(done_seen[0] && done_seen[1]), 1);
        chk("scoreboard_drained", 0, sb[0].size() + sb[1].size(), 0);
        m_run = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        drive(1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    // mode 0: back-to-back standard pairs; 1: alternate-cycle gaps; 2: random pairs, gaps, STARTs.
    task automatic run_fft(input int mode);
        logic [2:0] a;
        logic [2:0] b;
        drive(1'b1, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < TOTAL; i++) begin
            if (mode == 1 && i > 0) drive(1'b0, 1'b0, 3'(i), 3'(~i));
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    drive($urandom_range(0, 3) == 0, 1'b0, 3'($urandom), 3'($urandom));
                end
                a = 3'($urandom);
                b = 3'($urandom);
            end else begin
                a = std_a(i);
                b = std_b(i);
            end
            drive(mode == 2 && $urandom_range(0, 3) == 0, 1'b1, a, b);
            if (i == 0) begin
                chk("busy_running", 0, int'(bus0.busy), 1);
                chk("busy_running", 1, int'(bus1.busy), 1);
                chk("err_cleared_by_start", 0, int'(bus0.err), 0);
                chk("err_cleared_by_start", 1, int'(bus1.err), 0);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        wait_done();
    endtask

    task automatic flush_model();
        sb[0].delete();
        sb[1].delete();
        for (int g = 0; g < 2; g++) begin
            pend_lay[g] = 1'b0;
            pend_fft[g] = 1'b0;
            post_fft[g] = 1'b0;
            last_a[g]   = 3'd0;
            last_b[g]   = 3'd0;
        end
        m_run = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_cnt    = 0;
        flush_model();
        done_seen[0] = 1'b0;
        done_seen[1] = 1'b0;
        bus0.start = 1'b0; bus0.rd_valid = 1'b0; bus0.rd_a_addr = '0; bus0.rd_b_addr = '0;
        bus1.start = 1'b0; bus1.rd_valid = 1'b0; bus1.rd_a_addr = '0; bus1.rd_b_addr = '0;
        fork
            forever begin
                @(negedge clk);
                mon(0, bus0.wr_en, bus0.wr_a_addr, bus0.wr_b_addr, bus0.lay_done, bus0.fft_done,
                    bus0.busy);
                mon(1, bus1.wr_en, bus1.wr_a_addr, bus1.wr_b_addr, bus1.lay_done, bus1.fft_done,
                    bus1.busy);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("reset_wr_en", 0, int'(bus0.wr_en), 0);
                chk("reset_wr_en", 1, int'(bus1.wr_en), 0);
                chk("reset_busy", 0, int'(bus0.busy), 0);
                chk("reset_busy", 1, int'(bus1.busy), 0);
                chk("reset_err", 0, int'(bus0.err), 0);
                chk("reset_err", 1, int'(bus1.err), 0);
                rst_n = 1'b1;

                // Read issue while idle: discarded, sets sticky ERR.
                drive(1'b0, 1'b1, 3'd5, 3'd2);
                drive(1'b0, 1'b0, 3'd0, 3'd0);
                chk("err_idle_rd_valid", 0, int'(bus0.err), 1);
                chk("err_idle_rd_valid", 1, int'(bus1.err), 1);
                repeat (3) drive(1'b0, 1'b0, 3'd0, 3'd0);
                chk("err_sticky", 0, int'(bus0.err), 1);
                chk("err_sticky", 1, int'(bus1.err), 1);

                run_fft(0);
                run_fft(1);

                // Reset with five writes done and one pair still in the BF_LAT=2 pipeline.
                drive(1'b1, 1'b0, 3'd0, 3'd0);
                for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, std_a(i), std_b(i));
                drive(1'b0, 1'b0, 3'd0, 3'd0);
                @(negedge clk);
                #1;
                chk("inflight_before_reset", 0, sb[0].size(), 1);
                rst_n = 1'b0;
                flush_model();
                #1;
                chk("wr_en_in_reset", 0, int'(bus0.wr_en), 0);
                chk("wr_en_in_reset", 1, int'(bus1.wr_en), 0);
                chk("busy_in_reset", 0, int'(bus0.busy), 0);
                chk("busy_in_reset", 1, int'(bus1.busy), 0);
                repeat (2) drive(1'b0, 1'b0, 3'd0, 3'd0);
                rst_n = 1'b1;
                repeat (4) drive(1'b0, 1'b0, 3'd0, 3'd0);
                run_fft(0);

                for (int r = 0; r < 8; r++) run_fft(2);

                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end

endmodule
